// File: rtl/pcie_sw_pkg.sv
// pcie_sw_pkg: shared widths and FSM encodings for the PCIe class-FIFO switch
package pcie_sw_pkg;
    localparam int DATA_SIZE = 8;
    localparam int NUM_IN = 4;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_WAIT = 2'd2,
        ST_PUSH = 2'd3
    } state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first request at or after ptr
module rr_priority_picker (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx
);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] enc;
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[3:0];
        enc = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        gnt_valid = |req;
        gnt_idx = enc + ptr;
    end
endmodule

// File: rtl/pcie_rr_pop_arbiter.sv
// pcie_rr_pop_arbiter: round-robin drain of four class FIFOs into one egress stream
module pcie_rr_pop_arbiter
    import pcie_sw_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN-1:0]         fifo_empty,
    input  logic [NUM_IN*DATA_SIZE-1:0] fifo_data,
    input  logic [NUM_IN-1:0]         dest_pause,
    output logic [NUM_IN-1:0]         pop,
    output logic                      push,
    output logic [DATA_SIZE-1:0]      data_out,
    output logic [1:0]                grant_idx,
    output logic                      busy,
    output logic [7:0]                word_count
);
    state_t state, state_nxt;
    logic [1:0] rr_ptr;
    logic [1:0] gnt_idx;
    logic gnt_valid;
    logic go;
    logic [NUM_IN-1:0] pop_nxt;

    rr_priority_picker u_picker (
        .req(~fifo_empty),
        .ptr(rr_ptr),
        .gnt_valid(gnt_valid),
        .gnt_idx(gnt_idx)
    );

    // Requests and pause only matter in IDLE; later states run to PUSH unconditionally.
    always_comb begin
        go = (state == ST_IDLE) && gnt_valid && !(|dest_pause);
        state_nxt = (state == ST_IDLE) ? (go ? ST_POP : ST_IDLE) : state_t'(state + 2'd1);
        pop_nxt = '0;
        pop_nxt[gnt_idx] = go;
        busy = state != ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pop <= '0;
            push <= 1'b0;
            data_out <= '0;
            grant_idx <= 2'd0;
            word_count <= 8'd0;
            rr_ptr <= 2'd0;
        end else begin
            pop <= pop_nxt;
            push <= state == ST_WAIT;
            if (go)
                grant_idx <= gnt_idx;
            if (state == ST_WAIT)
                data_out <= fifo_data[grant_idx*DATA_SIZE +: DATA_SIZE];
            if (state == ST_PUSH) begin
                word_count <= word_count + 8'd1;
                rr_ptr <= grant_idx + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_pcie_rr_pop_arbiter.sv
// tb_pcie_rr_pop_arbiter: directed checks of pop/push timing, round robin, pause, reset and wrap
module tb_pcie_rr_pop_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] fifo_empty = 4'h0;
    logic [31:0] fifo_data = 32'h0;
    logic [3:0] dest_pause = 4'h0;
    logic [3:0] pop;
    logic push;
    logic [7:0] data_out;
    logic [1:0] grant_idx;
    logic busy;
    logic [7:0] word_count;
    int tests = 0;
    int fails = 0;
    int viol = 0;
    int n;
    int pops;
    logic [1:0] exp_g [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    pcie_rr_pop_arbiter dut (
        .clk(clk),
        .reset(reset),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .dest_pause(dest_pause),
        .pop(pop),
        .push(push),
        .data_out(data_out),
        .grant_idx(grant_idx),
        .busy(busy),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (reset && (((pop & (pop - 4'd1)) != 4'd0) || (|pop && push)))
            viol++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_push(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!push && cyc < 16);
        check("push_seen", {31'd0, push}, 32'd1);
    endtask

    initial begin
        // Reset with every FIFO holding data
        repeat (2) @(negedge clk);
        check("rst_pop", {28'd0, pop}, 32'd0);
        check("rst_push", {31'd0, push}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_wc", {24'd0, word_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {30'd0, grant_idx}, 32'd0);
        // Single source: FIFO2 holds 0xA5
        fifo_empty = 4'b1011;
        fifo_data = 32'h00A5_0000;
        reset = 1'b1;
        @(negedge clk);
        check("ss_pop", {28'd0, pop}, 32'h4);
        check("ss_grant", {30'd0, grant_idx}, 32'd2);
        check("ss_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("ss_wait_pop", {28'd0, pop}, 32'd0);
        check("ss_wait_push", {31'd0, push}, 32'd0);
        @(negedge clk);
        check("ss_push", {31'd0, push}, 32'd1);
        check("ss_data", {24'd0, data_out}, 32'hA5);
        @(negedge clk);
        check("ss_wc", {24'd0, word_count}, 32'd1);
        check("ss_push_low", {31'd0, push}, 32'd0);
        check("ss_idle", {31'd0, busy}, 32'd0);
        fifo_empty = 4'hF;
        // Round robin from a fresh pointer
        reset = 1'b0;
        repeat (2) @(negedge clk);
        fifo_empty = 4'h0;
        fifo_data = 32'h4433_2211;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_push(n);
            check("rr_gap", n, (i == 0) ? 32'd3 : 32'd4);
            check("rr_grant", {30'd0, grant_idx}, {30'd0, exp_g[i]});
            check("rr_data", {24'd0, data_out}, 32'h11 * (32'(exp_g[i]) + 32'd1));
        end
        // Pause held in IDLE blocks new pops
        fifo_empty = 4'hF;
        @(negedge clk);
        dest_pause = 4'b0010;
        fifo_empty = 4'h0;
        pops = 0;
        repeat (10) begin
            @(negedge clk);
            pops += int'(|pop);
        end
        check("pause_idle_pop", pops, 32'd0);
        check("pause_idle_busy", {31'd0, busy}, 32'd0);
        dest_pause = 4'h0;
        @(negedge clk);
        check("resume_pop", {28'd0, pop}, 32'h4);
        // Pause raised during POP still lets the push through
        dest_pause = 4'b1000;
        wait_push(n);
        check("pause_pop_gap", n, 32'd2);
        check("pause_pop_data", {24'd0, data_out}, 32'h33);
        pops = 0;
        repeat (8) begin
            @(negedge clk);
            pops += int'(|pop);
        end
        check("pause_hold_pop", pops, 32'd0);
        check("pause_hold_busy", {31'd0, busy}, 32'd0);
        dest_pause = 4'h0;
        @(negedge clk);
        check("pause_clear_pop", {28'd0, pop}, 32'h8);
        // Reset while in WAIT drops the transfer
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_push", {31'd0, push}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_pop", {28'd0, pop}, 32'd0);
        check("midrst_wc", {24'd0, word_count}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_first_pop", {28'd0, pop}, 32'h1);
        check("midrst_first_grant", {30'd0, grant_idx}, 32'd0);
        // Counter wraps after 256 pushes
        repeat (255) wait_push(n);
        @(negedge clk);
        check("wc_255", {24'd0, word_count}, 32'd255);
        wait_push(n);
        @(negedge clk);
        check("wc_wrap", {24'd0, word_count}, 32'd0);
        check("invariants", viol, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
